// File: rtl/vector_regfile.sv
// vector_regfile: 32 x VLEN vector register file, addressed as 64 slices of
// VFULEN bits ({vreg[4:0], slice}).
//   clk, rstn            : clock, asynchronous active-low reset
//   vdq_vrf_read_packet  : read request packet (vld/vaddr/rs_idx/rs_field_idx per port)
//   busy                 : a packet is still draining; new packets are ignored
//   vrf_rs_packet        : read responses, one-cycle vld per port, payload held
//   data_v0              : {slice1, slice0} of v0, straight from storage
//   wr0_*/wr1_*          : two masked slice write ports (wr0 has priority)
//   wr0/wr1_conflict     : write hits a slice being read this cycle (wr1 also
//                          flags a same-address collision with wr0)
package rrv64_core_vec_param_pkg;
  localparam int unsigned VLEN            = 128;
  localparam int unsigned VFULEN          = 64;
  localparam int unsigned VREG_ADDR_WIDTH = 6;
  localparam int unsigned VRF_RPORT_NUM   = 5;
  localparam int unsigned VSB_ENT_NUM     = 8;
  localparam int unsigned RD_PER_CYCLE    = 2;
  localparam int unsigned VREG_SLICES     = 1 << VREG_ADDR_WIDTH;

  typedef struct packed {
    logic [VRF_RPORT_NUM-1:0]                      vld;
    logic [VRF_RPORT_NUM-1:0][VREG_ADDR_WIDTH-1:0] vaddr;
    logic [VRF_RPORT_NUM-1:0][VSB_ENT_NUM-1:0]     rs_idx;
    logic [VRF_RPORT_NUM-1:0][1:0]                 rs_field_idx;
  } prf_pipereg_t;

  typedef struct packed {
    logic [VRF_RPORT_NUM-1:0]                  vld;
    logic [VRF_RPORT_NUM-1:0][VFULEN-1:0]      data;
    logic [VRF_RPORT_NUM-1:0][VSB_ENT_NUM-1:0] rs_idx;
    logic [VRF_RPORT_NUM-1:0][1:0]             rs_field_idx;
  } prf_rdata_t;
endpackage

module vector_regfile
  import rrv64_core_vec_param_pkg::*;
(
  input  logic                       clk,
  input  logic                       rstn,
  input  prf_pipereg_t               vdq_vrf_read_packet,
  output logic                       busy,
  output logic [VLEN-1:0]            data_v0,
  output prf_rdata_t                 vrf_rs_packet,
  input  logic                       wr0_vld,
  input  logic [VREG_ADDR_WIDTH-1:0] waddr0,
  input  logic [VFULEN-1:0]          wmask0,
  input  logic [VFULEN-1:0]          wdata0,
  output logic                       wr0_conflict,
  input  logic                       wr1_vld,
  input  logic [VREG_ADDR_WIDTH-1:0] waddr1,
  input  logic [VFULEN-1:0]          wmask1,
  input  logic [VFULEN-1:0]          wdata1,
  output logic                       wr1_conflict
);

  logic [VFULEN-1:0]        r_mem [VREG_SLICES];
  prf_pipereg_t             r_pkt;
  logic [VRF_RPORT_NUM-1:0] r_pending;
  prf_rdata_t               r_out;

  logic [VRF_RPORT_NUM-1:0] w_sel;
  logic                     w_busy;
  logic                     w_accept;
  logic                     w_same_addr;
  logic                     w_hit0;
  logic                     w_hit1;
  logic [VFULEN-1:0]        w_merge1;
  logic [VFULEN-1:0]        w_base0;
  logic [VFULEN-1:0]        w_merge0;

  assign w_busy   = |r_pending;
  assign busy     = w_busy;
  assign w_accept = !w_busy && (|vdq_vrf_read_packet.vld);
  assign data_v0  = {r_mem[1], r_mem[0]};
  assign vrf_rs_packet = r_out;

  // Same-address dual write: wr1 is merged first and wr0 is merged on top,
  // so wr0 owns the bits of wmask0 and wr1 only lands where wmask0 is clear.
  assign w_same_addr = wr0_vld && wr1_vld && (waddr0 == waddr1);
  assign w_merge1    = (r_mem[waddr1] & ~wmask1) | (wdata1 & wmask1);
  assign w_base0     = w_same_addr ? w_merge1 : r_mem[waddr0];
  assign w_merge0    = (w_base0 & ~wmask0) | (wdata0 & wmask0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < VREG_SLICES; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (wr1_vld) r_mem[waddr1] <= w_merge1;
      if (wr0_vld) r_mem[waddr0] <= w_merge0;
    end
  end

  // Pick the lowest-indexed pending ports, at most RD_PER_CYCLE per cycle.
  always_comb begin
    int unsigned n;
    n     = 0;
    w_sel = '0;
    for (int unsigned i = 0; i < VRF_RPORT_NUM; i++) begin
      if (r_pending[i] && (n < RD_PER_CYCLE)) begin
        w_sel[i] = 1'b1;
        n        = n + 1;
      end
    end
  end

  always_comb begin
    w_hit0 = 1'b0;
    w_hit1 = 1'b0;
    for (int unsigned i = 0; i < VRF_RPORT_NUM; i++) begin
      if (w_sel[i] && (r_pkt.vaddr[i] == waddr0)) w_hit0 = 1'b1;
      if (w_sel[i] && (r_pkt.vaddr[i] == waddr1)) w_hit1 = 1'b1;
    end
  end

  assign wr0_conflict = wr0_vld && w_hit0;
  assign wr1_conflict = wr1_vld && (w_hit1 || w_same_addr);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pkt     <= '0;
      r_pending <= '0;
    end else if (w_accept) begin
      r_pkt     <= vdq_vrf_read_packet;
      r_pending <= vdq_vrf_read_packet.vld;
    end else begin
      r_pending <= r_pending & ~w_sel;
    end
  end

  // Reads sample storage before this edge's writes land: no write bypass.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_out <= '0;
    end else begin
      r_out.vld <= w_sel;
      for (int unsigned i = 0; i < VRF_RPORT_NUM; i++) begin
        if (w_sel[i]) begin
          r_out.data[i]         <= r_mem[r_pkt.vaddr[i]];
          r_out.rs_idx[i]       <= r_pkt.rs_idx[i];
          r_out.rs_field_idx[i] <= r_pkt.rs_field_idx[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_vector_regfile.sv
module tb_vector_regfile;
  import rrv64_core_vec_param_pkg::*;

  logic         clk = 1'b0;
  logic         rstn;
  prf_pipereg_t rd_pkt;
  logic         busy;
  logic [127:0] data_v0;
  prf_rdata_t   vrf_rs_packet;
  logic         wr0_vld, wr1_vld;
  logic [5:0]   waddr0, waddr1;
  logic [63:0]  wmask0, wmask1, wdata0, wdata1;
  logic         wr0_conflict, wr1_conflict;

  vector_regfile dut (
    .clk                 (clk),
    .rstn                (rstn),
    .vdq_vrf_read_packet (rd_pkt),
    .busy                (busy),
    .data_v0             (data_v0),
    .vrf_rs_packet       (vrf_rs_packet),
    .wr0_vld             (wr0_vld),
    .waddr0              (waddr0),
    .wmask0              (wmask0),
    .wdata0              (wdata0),
    .wr0_conflict        (wr0_conflict),
    .wr1_vld             (wr1_vld),
    .waddr1              (waddr1),
    .wmask1              (wmask1),
    .wdata1              (wdata1),
    .wr1_conflict        (wr1_conflict)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          port;
    logic [63:0] data;
    logic [7:0]  rs;
    logic [1:0]  fld;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  logic [63:0] model [64];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %h required %h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_rsp(input int port, input logic [63:0] data,
                            input logic [7:0] rs, input logic [1:0] fld);
    exp_t e;
    e.port = port; e.data = data; e.rs = rs; e.fld = fld;
    q.push_back(e);
  endtask

  task automatic drive_wr(input logic v0, input logic [5:0] a0, input logic [63:0] m0,
                          input logic [63:0] d0, input logic v1, input logic [5:0] a1,
                          input logic [63:0] m1, input logic [63:0] d1);
    wr0_vld = v0; waddr0 = a0; wmask0 = m0; wdata0 = d0;
    wr1_vld = v1; waddr1 = a1; wmask1 = m1; wdata1 = d1;
  endtask

  task automatic clr_wr();
    drive_wr(1'b0, '0, '0, '0, 1'b0, '0, '0, '0);
  endtask

  task automatic wr(input logic v0, input logic [5:0] a0, input logic [63:0] m0,
                    input logic [63:0] d0, input logic v1, input logic [5:0] a1,
                    input logic [63:0] m1, input logic [63:0] d1);
    drive_wr(v0, a0, m0, d0, v1, a1, m1, d1);
    tick();
    clr_wr();
  endtask

  // Drives the packet for one edge (accepted when busy is low), then drops vld.
  task automatic issue(input prf_pipereg_t p);
    rd_pkt = p;
    tick();
    rd_pkt = '0;
  endtask

  task automatic wait_drain(input string name);
    for (int k = 0; k < 20 && (busy || q.size() != 0); k++) tick();
    checks++;
    if (busy || q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain_timeout: busy %0b outstanding %0d required busy 0 outstanding 0",
               name, busy, q.size());
    end
  endtask

  // Scoreboard monitor: every presented response must match the oldest expectation.
  always @(negedge clk) begin
    if (rstn) begin
      for (int p = 0; p < 5; p++) begin
        if (vrf_rs_packet.vld[p]) begin
          checks++;
          if (q.size() == 0) begin
            errors++;
            $display("FAIL rsp_unexpected: port %0d data %h required no response",
                     p, vrf_rs_packet.data[p]);
          end else begin
            mon_e = q.pop_front();
            if (mon_e.port != p || vrf_rs_packet.data[p] !== mon_e.data ||
                vrf_rs_packet.rs_idx[p] !== mon_e.rs ||
                vrf_rs_packet.rs_field_idx[p] !== mon_e.fld) begin
              errors++;
              $display("FAIL rsp: actual port %0d data %h rs %h fld %0d required port %0d data %h rs %h fld %0d",
                       p, vrf_rs_packet.data[p], vrf_rs_packet.rs_idx[p],
                       vrf_rs_packet.rs_field_idx[p], mon_e.port, mon_e.data, mon_e.rs, mon_e.fld);
            end
          end
        end
      end
    end
  end

  initial begin
    prf_pipereg_t p;
    logic [63:0]  d0, d1;

    rstn = 1'b0;
    rd_pkt = '0;
    clr_wr();
    #1;
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_rs_packet", 128'(|vrf_rs_packet), 128'd0);
    chk("rst_data_v0", data_v0, 128'd0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    repeat (2) tick();
    chk("idle_busy", 128'(busy), 128'd0);
    chk("idle_vld", 128'(vrf_rs_packet.vld), 128'd0);

    // Fill all 64 slices in pairs.
    for (int i = 0; i < 64; i += 2) begin
      d0 = {$urandom, $urandom};
      d1 = {$urandom, $urandom};
      model[i] = d0;
      model[i+1] = d1;
      wr(1'b1, 6'(i), '1, d0, 1'b1, 6'(i + 1), '1, d1);
    end

    // Full 5-port packet: latency 1/2/3 cycles, busy high for 3 cycles.
    p = '0;
    p.vld = 5'b11111;
    for (int i = 0; i < 5; i++) begin
      p.vaddr[i]        = 6'(2 * i + 1);
      p.rs_idx[i]       = 8'(8'h10 + i);
      p.rs_field_idx[i] = 2'(i);
      expect_rsp(i, model[2 * i + 1], 8'(8'h10 + i), 2'(i));
    end
    issue(p);
    chk("full_e0_busy", 128'(busy), 128'd1);
    chk("full_e0_vld", 128'(vrf_rs_packet.vld), 128'd0);
    tick();
    chk("full_e1_busy", 128'(busy), 128'd1);
    chk("full_e1_vld", 128'(vrf_rs_packet.vld), 128'b00011);
    tick();
    chk("full_e2_busy", 128'(busy), 128'd1);
    chk("full_e2_vld", 128'(vrf_rs_packet.vld), 128'b01100);
    tick();
    chk("full_e3_busy", 128'(busy), 128'd0);
    chk("full_e3_vld", 128'(vrf_rs_packet.vld), 128'b10000);
    wait_drain("full");

    // v0 exposed whole.
    wr(1'b1, 6'd0, '1, 64'h0123_4567_89AB_CDEF, 1'b1, 6'd1, '1, 64'hFEDC_BA98_7654_3210);
    chk("data_v0", data_v0, 128'hFEDC_BA98_7654_3210_0123_4567_89AB_CDEF);

    // Partial mask write.
    wr(1'b1, 6'd2, '1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, '0, '0, '0);
    wr(1'b1, 6'd2, 64'h0000_0000_FFFF_FFFF, 64'd0, 1'b0, '0, '0, '0);
    p = '0;
    p.vld = 5'b00001; p.vaddr[0] = 6'd2; p.rs_idx[0] = 8'hA2; p.rs_field_idx[0] = 2'd3;
    expect_rsp(0, 64'hFFFF_FFFF_0000_0000, 8'hA2, 2'd3);
    issue(p);
    wait_drain("mask");

    // Same-address dual write.
    drive_wr(1'b1, 6'd4, 64'h0000_0000_FFFF_FFFF, 64'h1111_1111_1111_1111,
             1'b1, 6'd4, '1, 64'h2222_2222_2222_2222);
    #1;
    chk("dual_wr1_conflict", 128'(wr1_conflict), 128'd1);
    chk("dual_wr0_conflict", 128'(wr0_conflict), 128'd0);
    tick();
    clr_wr();
    p = '0;
    p.vld = 5'b00010; p.vaddr[1] = 6'd4; p.rs_idx[1] = 8'h44; p.rs_field_idx[1] = 2'd1;
    expect_rsp(1, 64'h2222_2222_1111_1111, 8'h44, 2'd1);
    issue(p);
    wait_drain("dual");

    // Write during service returns old data, then new data.
    wr(1'b1, 6'd6, '1, 64'h0606_0606_0606_0606, 1'b0, '0, '0, '0);
    p = '0;
    p.vld = 5'b00100; p.vaddr[2] = 6'd6; p.rs_idx[2] = 8'h66; p.rs_field_idx[2] = 2'd2;
    expect_rsp(2, 64'h0606_0606_0606_0606, 8'h66, 2'd2);
    issue(p);
    drive_wr(1'b1, 6'd6, '1, 64'hDEAD_BEEF_CAFE_F00D, 1'b0, '0, '0, '0);
    #1;
    chk("rw_wr0_conflict", 128'(wr0_conflict), 128'd1);
    tick();
    clr_wr();
    wait_drain("rw_old");
    expect_rsp(2, 64'hDEAD_BEEF_CAFE_F00D, 8'h66, 2'd2);
    issue(p);
    wait_drain("rw_new");

    // Sparse mask compacted into one service cycle.
    p = '0;
    p.vld = 5'b10100;
    p.vaddr[2] = 6'd10; p.rs_idx[2] = 8'h0A; p.rs_field_idx[2] = 2'd0;
    p.vaddr[4] = 6'd12; p.rs_idx[4] = 8'h0C; p.rs_field_idx[4] = 2'd1;
    expect_rsp(2, model[10], 8'h0A, 2'd0);
    expect_rsp(4, model[12], 8'h0C, 2'd1);
    issue(p);
    tick();
    chk("sparse_vld", 128'(vrf_rs_packet.vld), 128'b10100);
    chk("sparse_busy", 128'(busy), 128'd0);
    wait_drain("sparse");

    // Empty packet is not accepted.
    p = '0;
    p.vaddr[0] = 6'd3;
    issue(p);
    chk("empty_busy", 128'(busy), 128'd0);
    tick();
    chk("empty_vld", 128'(vrf_rs_packet.vld), 128'd0);

    // Reset mid-drain: no responses afterwards.
    p = '0;
    p.vld = 5'b11111;
    issue(p);
    rstn = 1'b0;
    #1;
    chk("middrain_busy", 128'(busy), 128'd0);
    chk("middrain_vld", 128'(vrf_rs_packet.vld), 128'd0);
    repeat (2) tick();
    rstn = 1'b1;
    repeat (4) tick();
    chk("postrst_busy", 128'(busy), 128'd0);
    chk("postrst_data_v0", data_v0, 128'd0);
    chk("postrst_outstanding", 128'(q.size()), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
